// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer: per-channel FSM states
// and the counter-width helper.
package debounce_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        HOLD_DLY = 2'd1,
        HOLD_RPT = 2'd2
    } btn_state_t;

    // Bits needed to hold any value from 0 up to max(a, b) inclusive.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchronizer, stability filter and the
// press / hold / auto-repeat FSM. All outputs are registered.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 48,
    parameter int REPEAT_RATE  = 10
) (
    input  logic               clock_in,
    input  logic               rst,
    input  logic               raw_i,
    output logic               level_o,
    output logic               press_o,
    output logic               release_o,
    output logic               repeat_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CW = clog2_max(STABLE_CNT, 0);
    localparam int HW = clog2_max(REPEAT_DELAY, REPEAT_RATE);

    localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] DLY_TC = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HW-1:0] RPT_TC = HW'(REPEAT_RATE - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          flip;
    logic          rise, fall;
    btn_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            state_q   <= IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // Any sample agreeing with the current level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            flip    = 1'b1;
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Edge pulses are registered on the same edge the level flips.
    assign rise = flip & ~level_q;
    assign fall = flip & level_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HOLD_DLY;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            HOLD_DLY: begin
                if (fall) begin
                    state_d   = IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (REPEAT_DELAY != 0) begin
                    if (hold_q == DLY_TC) begin
                        state_d  = HOLD_RPT;
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            HOLD_RPT: begin
                if (fall) begin
                    state_d   = IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (hold_q == RPT_TC) begin
                    hold_d   = '0;
                    repeat_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
    assign state_o   = state_q;

endmodule

// File: rtl/button_debouncer.sv
// NUM_BTN independent debounced buttons with press, release and auto-repeat
// pulses, clocked by the ~95 Hz slow clock. FSM states exposed for debug.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_CNT   = 3,
    parameter int REPEAT_DELAY = 48,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                       clock_in,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic [NUM_BTN-1:0]         btn_release,
    output logic [NUM_BTN-1:0]         btn_repeat,
    output logic [NUM_BTN*STATE_W-1:0] btn_state_dbg
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .clock_in (clock_in),
            .rst      (rst),
            .raw_i    (btn_raw[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g]),
            .repeat_o (btn_repeat[g]),
            .state_o  (btn_state_dbg[g*STATE_W +: STATE_W])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a default build and a REPEAT_DELAY=0 build share
// one stimulus; a window/elapsed-time reference model predicts every output.
module tb_button_debouncer;
    import debounce_pkg::*;

    localparam int NB = 4;
    localparam int SC = 3;
    localparam int RD = 48;
    localparam int RR = 10;
    localparam int W  = NB * STATE_W + 4 * NB;

    logic          clock_in = 1'b0;
    logic          rst      = 1'b1;
    logic [NB-1:0] btn_raw  = '0;

    logic [NB-1:0]         lvl_a, prs_a, rel_a, rep_a;
    logic [NB-1:0]         lvl_b, prs_b, rel_b, rep_b;
    logic [NB*STATE_W-1:0] st_a, st_b;
    logic [W-1:0]          got_a, got_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: one expected word per build per clock edge.
    logic [W-1:0] exp_q[$];

    // Reference model: raw sample history (bit 0 newest), debounced level,
    // and edges elapsed since the press for each build.
    logic [15:0] hist[NB];
    logic        m_lvl[NB];
    int          m_t[2][NB];

    button_debouncer #(
        .NUM_BTN(NB), .STABLE_CNT(SC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock_in(clock_in), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a),
        .btn_repeat(rep_a), .btn_state_dbg(st_a)
    );

    button_debouncer #(
        .NUM_BTN(NB), .STABLE_CNT(SC), .REPEAT_DELAY(0), .REPEAT_RATE(RR)
    ) dut_nr (
        .clock_in(clock_in), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b),
        .btn_repeat(rep_b), .btn_state_dbg(st_b)
    );

    assign got_a = {st_a, lvl_a, prs_a, rel_a, rep_a};
    assign got_b = {st_b, lvl_b, prs_b, rel_b, rep_b};

    // ---------------- clock / reset ----------------
    always #5 clock_in = ~clock_in;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_edge();
        logic [NB*STATE_W-1:0] e_st[2];
        logic [NB-1:0]         e_rp[2];
        logic [NB-1:0]         e_l, e_p, e_r;
        logic                  all_opp, rise, fall;
        int                    rd;
        e_l = '0; e_p = '0; e_r = '0;
        for (int m = 0; m < 2; m++) begin
            e_st[m] = '0;
            e_rp[m] = '0;
        end
        if (rst) begin
            for (int c = 0; c < NB; c++) begin
                hist[c]   = '0;
                m_lvl[c]  = 1'b0;
                m_t[0][c] = 0;
                m_t[1][c] = 0;
            end
        end else begin
            for (int c = 0; c < NB; c++) begin
                hist[c] = {hist[c][14:0], btn_raw[c]};
                // Two sync stages, then SC consecutive samples opposing the level.
                all_opp = 1'b1;
                for (int k = 0; k < SC; k++)
                    if (hist[c][2+k] == m_lvl[c]) all_opp = 1'b0;
                rise = all_opp & ~m_lvl[c];
                fall = all_opp & m_lvl[c];
                if (all_opp) m_lvl[c] = ~m_lvl[c];
                e_l[c] = m_lvl[c];
                e_p[c] = rise;
                e_r[c] = fall;
                for (int m = 0; m < 2; m++) begin
                    rd = (m == 0) ? RD : 0;
                    if (rise) begin
                        m_t[m][c] = 0;
                    end else if (m_lvl[c]) begin
                        m_t[m][c]++;
                        if (rd > 0 && (m_t[m][c] == rd ||
                            (m_t[m][c] > rd && (m_t[m][c] - rd) % RR == 0)))
                            e_rp[m][c] = 1'b1;
                    end
                    if (!m_lvl[c])
                        e_st[m][c*STATE_W +: STATE_W] = IDLE;
                    else if (rd > 0 && m_t[m][c] >= rd)
                        e_st[m][c*STATE_W +: STATE_W] = HOLD_RPT;
                    else
                        e_st[m][c*STATE_W +: STATE_W] = HOLD_DLY;
                end
            end
        end
        for (int m = 0; m < 2; m++)
            exp_q.push_back({e_st[m], e_l, e_p, e_r, e_rp[m]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag);
        logic [W-1:0] e;
        @(posedge clock_in);
        #1;
        model_edge();
        e = exp_q.pop_front();
        check_val({tag, "/dflt"}, 32'(got_a), 32'(e));
        e = exp_q.pop_front();
        check_val({tag, "/nrpt"}, 32'(got_b), 32'(e));
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    // Asserts reset between edges, checks the immediate clear, then releases it.
    task automatic async_reset(input int edges, input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_val({tag, "/async_a"}, 32'(got_a), 32'(0));
        check_val({tag, "/async_b"}, 32'(got_b), 32'(0));
        run(edges, {tag, "/in_rst"});
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        #2;
        check_val("reset_a", 32'(got_a), 32'(0));
        check_val("reset_b", 32'(got_b), 32'(0));
        run(3, "reset");
        rst = 1'b0;
        run(4, "idle");

        btn_raw[0] = 1'b1;
        run(20, "clean_hold");
        btn_raw[0] = 1'b0;
        run(12, "clean_rel");

        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = (i % 2 == 0);
            step("bounce");
        end
        btn_raw[1] = 1'b1;
        run(15, "bounce_hold");
        btn_raw[1] = 1'b0;
        run(12, "bounce_rel");

        btn_raw[2] = 1'b1;
        run(100, "repeat_hold");
        btn_raw[2] = 1'b0;
        run(20, "repeat_rel");

        // Fall lands on the same edge as the first repeat terminal count.
        btn_raw[2] = 1'b1;
        run(RD, "boundary_hold");
        btn_raw[2] = 1'b0;
        run(15, "boundary_rel");

        btn_raw[3] = 1'b1;
        run(70, "rst_hold");
        async_reset(3, "rst_mid");
        run(10, "rst_rehold");
        btn_raw[3] = 1'b0;
        run(12, "rst_rel");

        btn_raw[0] = 1'b1;
        run(2, "indep_a");
        btn_raw[3] = 1'b1;
        run(60, "indep_hold");
        btn_raw = '0;
        run(12, "indep_rel");

        btn_raw = '1;
        run(200, "long_hold");
        btn_raw = '0;
        run(12, "long_rel");

        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 3))
                0:       p = 1;
                1:       p = 6;
                2:       p = 25;
                default: p = 90;
            endcase
            if (seg == 5) async_reset(2, "rand_rst");
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < NB; c++)
                    if ($urandom_range(0, p) == 0) btn_raw[c] = ~btn_raw[c];
                step("random");
            end
        end
        btn_raw = '0;
        run(12, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
